weight_load_sched: RTL and testbench
====================================

Name: weight_load_sched

Overview:
Sequencer that feeds the MAC-array weight load unit. It accepts one load command per kernel group and drains a 32-bit weight stream (from the weight BIU/DMA FIFO) into a strictly ordered series of weight write beats (waddr/wdata/wen). It also tracks occupancy of the two ping-pong weight banks, so a new load never overwrites a bank the array is still computing with.

Parameters:
DW, 32, weight word width (waddr is fixed at 32 bits).
IN_CH, 16, input channels per kernel group; inner loop count, index field waddr[3:0].
KK, 9, 3x3 kernel taps; outer loop count for 3x3 loads, offset field waddr[9:6].

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
cmd_valid  in  1  load command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_is_1x1  in  1  1 = 1x1 kernel, 0 = 3x3
cmd_out_ch  in  8  output-channel group, placed in waddr[30:23]
wt_valid  in  1  weight stream word valid
wt_ready  out  1  weight stream ready
wt_data  in  DW  weight word
weight_waddr  out  32  write address to WLU
weight_wdata  out  DW  write data to WLU
weight_wen  out  1  write strobe
bank_release  in  1  pulse from compute: oldest full bank consumed
load_done  out  1  one-cycle pulse, a bank finished loading
banks_full  out  2  number of full banks, 0..2
err_underflow  out  1  sticky: bank_release seen with banks_full==0

Behaviour:
- Reset: state IDLE; all counters 0; cmd_ready=0, wt_ready=0, weight_wen=0, weight_waddr=0, weight_wdata=0, load_done=0, banks_full=0, err_underflow=0. Reset mid-load aborts the load with no completion pulse; partial bank contents are discarded (not counted).
- States: IDLE, WAIT_BANK, LOAD, DONE.
  - IDLE: cmd_ready=1. On cmd handshake, latch is_1x1 and out_ch, clear tap counter k and channel counter c, go to WAIT_BANK.
  - WAIT_BANK: if banks_full<2, go to LOAD; else hold.
  - LOAD: wt_ready=1. Each wt handshake emits one beat. c increments 0..IN_CH-1 and wraps; on wrap, k increments. The final beat is c==IN_CH-1 and (is_1x1 or k==KK-1); on the final handshake go to DONE. A 3x3 load is 144 beats and a 1x1 load is 16 beats. wt_valid low stalls with no beat and no counter change.
  - DONE: load_done=1 for exactly one cycle, banks_full counter increments, go to IDLE.
- Beat format, registered with 1-cycle latency after the handshake cycle: weight_wen=1. weight_wdata=wt_data. weight_waddr[31]=is_1x1, [30:23]=out_ch, [9:6]=k (forced 0 when is_1x1), [3:0]=c, all other bits 0. When no handshake occurs, weight_wen=0 and addr/data hold their last values.
- Bank ordering: in_ch 8..15 (waddr[3]=1) always follow 0..7 within each tap, so the ping-pong half select stays monotonic inside a tap.
- banks_full arithmetic:
  - increment on DONE, decrement on bank_release;
  - both in the same cycle: unchanged;
  - bank_release at 0: stays 0 and err_underflow sets (cleared only by reset);
  - DONE cannot occur at 2, because WAIT_BANK blocks.
- No command is accepted outside IDLE; a back-to-back command is accepted on the cycle after DONE.

Decomposition:
- Shared package wl_pkg holds: state encoding (IDLE/WAIT_BANK/LOAD/DONE); waddr field positions (KSEL_BIT=31, OCH_MSB/LSB=30/23, TAP_MSB/LSB=9/6, CH_MSB/LSB=3/0); constants IN_CH=16, KK=9, BANKS=2.
- One natural sub-module: wl_bank_tracker. It owns the banks_full counter, the increment/decrement/simultaneous rules and err_underflow; the FSM/counter/beat logic stays in the top.

Test Plan:
- 1x1 command out_ch=0x05, stream words 0..15 continuous -> 16 beats, waddr = 0x82800000 | c for c=0..15, wdata matches, load_done 1 cycle after the last beat, banks_full=1.
- 3x3 command out_ch=0x01, 144 words with wt_valid toggling every other cycle -> exactly 144 beats. First waddr is 0x00800000. Beat 16 has waddr 0x00800040. The last beat has waddr 0x0080020F. No beats while wt_valid=0.
- Two back-to-back loads with no release, then issue a third -> third stays in WAIT_BANK with wt_ready=0. Pulse bank_release -> banks_full 2->1, the load proceeds, and after DONE banks_full=2.
- bank_release in the same cycle as load_done with banks_full=1 -> banks_full stays 1.
- bank_release with banks_full=0 -> banks_full=0, err_underflow=1 and sticky.
- Assert rst_n=0 at beat 50 of a 3x3 load -> next cycle all outputs at reset values, banks_full=0, no load_done. A new 1x1 command after reset completes normally.

Source files
------------

// File: rtl/wl_pkg.sv
// ============================================================================
// wl_pkg : shared types, waddr field map and loop constants for weight_load_sched
// Rev 1.0
// ============================================================================
`default_nettype none

package wl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_BANK = 2'd1,
      ST_LOAD      = 2'd2,
      ST_DONE      = 2'd3
   } wl_state_t;

   localparam int KSEL_BIT = 31;
   localparam int OCH_MSB  = 30;
   localparam int OCH_LSB  = 23;
   localparam int TAP_MSB  = 9;
   localparam int TAP_LSB  = 6;
   localparam int CH_MSB   = 3;
   localparam int CH_LSB   = 0;

   localparam int IN_CH = 16;
   localparam int KK    = 9;
   localparam int BANKS = 2;

   localparam int CW = CH_MSB - CH_LSB + 1;
   localparam int TW = TAP_MSB - TAP_LSB + 1;
   localparam int OW = OCH_MSB - OCH_LSB + 1;

   // Unused address bits stay zero; 1x1 loads have a single tap, so its field reads 0.
   function automatic logic [31:0] wl_make_waddr(
      input logic          is_1x1,
      input logic [OW-1:0] out_ch,
      input logic [TW-1:0] tap,
      input logic [CW-1:0] ch
   );
      logic [31:0] a;
      a                   = '0;
      a[KSEL_BIT]         = is_1x1;
      a[OCH_MSB:OCH_LSB]  = out_ch;
      a[TAP_MSB:TAP_LSB]  = is_1x1 ? '0 : tap;
      a[CH_MSB:CH_LSB]    = ch;
      return a;
   endfunction

endpackage

`default_nettype wire

// File: rtl/wl_bank_tracker.sv
// ============================================================================
// wl_bank_tracker : full-bank occupancy counter for the ping-pong weight banks
// Rev 1.0
// ============================================================================
`default_nettype none

module wl_bank_tracker
   import wl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_inc,
   input  logic       i_dec,
   output logic [1:0] o_banks_full,
   output logic       o_err_underflow
);

   localparam logic [1:0] c_BANKS_MAX = 2'(BANKS);

   logic [1:0] r_cnt;
   logic       r_err;

   // A fill and a release in the same cycle cancel; a release with nothing full is an error.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= 2'd0;
         r_err <= 1'b0;
      end else if (i_inc && !i_dec) begin
         if (r_cnt != c_BANKS_MAX) begin
            r_cnt <= r_cnt + 2'd1;
         end
      end else if (i_dec && !i_inc) begin
         if (r_cnt == 2'd0) begin
            r_err <= 1'b1;
         end else begin
            r_cnt <= r_cnt - 2'd1;
         end
      end
   end

   assign o_banks_full    = r_cnt;
   assign o_err_underflow = r_err;

endmodule

`default_nettype wire

// File: rtl/weight_load_sched.sv
// ============================================================================
// weight_load_sched : turns load commands plus a weight stream into ordered WLU write beats
// Rev 1.0
// ============================================================================
`default_nettype none

module weight_load_sched
   import wl_pkg::*;
#(
   parameter int DW    = 32,
   parameter int IN_CH = 16,
   parameter int KK    = 9
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_is_1x1,
   input  logic [7:0]    cmd_out_ch,
   input  logic          wt_valid,
   output logic          wt_ready,
   input  logic [DW-1:0] wt_data,
   output logic [31:0]   weight_waddr,
   output logic [DW-1:0] weight_wdata,
   output logic          weight_wen,
   input  logic          bank_release,
   output logic          load_done,
   output logic [1:0]    banks_full,
   output logic          err_underflow
);

   localparam logic [CW-1:0] c_CH_LAST  = CW'(IN_CH - 1);
   localparam logic [TW-1:0] c_TAP_LAST = TW'(KK - 1);
   localparam logic [1:0]    c_BANKS    = 2'(BANKS);

   wl_state_t     r_state;
   wl_state_t     w_state_nxt;

   logic          r_is_1x1;
   logic [7:0]    r_out_ch;
   logic [TW-1:0] r_tap;
   logic [CW-1:0] r_ch;

   logic [31:0]   r_waddr;
   logic [DW-1:0] r_wdata;
   logic          r_wen;

   logic          w_cmd_hs;
   logic          w_wt_hs;
   logic          w_last_ch;
   logic          w_last_beat;
   logic [1:0]    w_banks_full;
   logic          w_err_underflow;

   assign w_cmd_hs    = cmd_valid & cmd_ready;
   assign w_wt_hs     = wt_valid & wt_ready;
   assign w_last_ch   = (r_ch == c_CH_LAST);
   assign w_last_beat = w_last_ch & (r_is_1x1 | (r_tap == c_TAP_LAST));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // cmd_ready is qualified by rst_n so it reads 0 while reset is held.
   always_comb begin
      w_state_nxt = r_state;
      cmd_ready   = 1'b0;
      wt_ready    = 1'b0;
      load_done   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            cmd_ready = rst_n;
            if (cmd_valid) begin
               w_state_nxt = ST_WAIT_BANK;
            end
         end
         ST_WAIT_BANK: begin
            if (w_banks_full < c_BANKS) begin
               w_state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            wt_ready = 1'b1;
            if (wt_valid && w_last_beat) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            load_done   = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Channel is the inner loop so the upper half of a tap (ch 8..15) always follows the lower half.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_is_1x1 <= 1'b0;
         r_out_ch <= 8'd0;
         r_tap    <= '0;
         r_ch     <= '0;
      end else if (w_cmd_hs) begin
         r_is_1x1 <= cmd_is_1x1;
         r_out_ch <= cmd_out_ch;
         r_tap    <= '0;
         r_ch     <= '0;
      end else if (w_wt_hs) begin
         r_ch <= w_last_ch ? '0 : r_ch + 1'b1;
         if (w_last_ch && !w_last_beat) begin
            r_tap <= r_tap + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wen   <= 1'b0;
         r_waddr <= 32'd0;
         r_wdata <= '0;
      end else begin
         r_wen <= w_wt_hs;
         if (w_wt_hs) begin
            r_waddr <= wl_make_waddr(r_is_1x1, r_out_ch, r_tap, r_ch);
            r_wdata <= wt_data;
         end
      end
   end

   assign weight_wen   = r_wen;
   assign weight_waddr = r_waddr;
   assign weight_wdata = r_wdata;

   wl_bank_tracker u_bank_tracker (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_inc           (load_done),
      .i_dec           (bank_release),
      .o_banks_full    (w_banks_full),
      .o_err_underflow (w_err_underflow)
   );

   assign banks_full    = w_banks_full;
   assign err_underflow = w_err_underflow;

endmodule

`default_nettype wire

// File: tb/tb_weight_load_sched.sv
// ============================================================================
// tb_weight_load_sched : directed self-checking bench for weight_load_sched
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_weight_load_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_is_1x1;
   logic [7:0]  cmd_out_ch;
   logic        wt_valid;
   logic        wt_ready;
   logic [31:0] wt_data;
   logic [31:0] weight_waddr;
   logic [31:0] weight_wdata;
   logic        weight_wen;
   logic        bank_release;
   logic        load_done;
   logic [1:0]  banks_full;
   logic        err_underflow;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_beats;
   logic [31:0] beat_addr [0:143];

   always #5 clk = ~clk;

   weight_load_sched #(.DW(32), .IN_CH(16), .KK(9)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_is_1x1    (cmd_is_1x1),
      .cmd_out_ch    (cmd_out_ch),
      .wt_valid      (wt_valid),
      .wt_ready      (wt_ready),
      .wt_data       (wt_data),
      .weight_waddr  (weight_waddr),
      .weight_wdata  (weight_wdata),
      .weight_wen    (weight_wen),
      .bank_release  (bank_release),
      .load_done     (load_done),
      .banks_full    (banks_full),
      .err_underflow (err_underflow)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_addr(input logic is1x1, input logic [7:0] och, input int idx);
      int k;
      int c;
      k = idx / 16;
      c = idx % 16;
      return {is1x1, och, 13'd0, (is1x1 ? 4'd0 : 4'(k)), 2'd0, 4'(c)};
   endfunction

   task automatic pulse_release();
      bank_release = 1'b1;
      step();
      bank_release = 1'b0;
   endtask

   task automatic send_cmd(input logic is1x1, input logic [7:0] och);
      int t;
      t = 0;
      while (cmd_ready !== 1'b1 && t < 50) begin
         step();
         t++;
      end
      n_checks++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", cmd_ready);
      end
      cmd_valid  = 1'b1;
      cmd_is_1x1 = is1x1;
      cmd_out_ch = och;
      step();
      cmd_valid  = 1'b0;
   endtask

   // Drives a whole load and checks every cycle's beat against the address model.
   task automatic stream(input logic is1x1, input logic [7:0] och, input bit toggle,
                         input logic [31:0] base, input int abort_at, input bit rel_at_done);
      int          total;
      int          sent;
      int          cyc;
      bit          exp_wen;
      bit          last_hs;
      bit          finished;
      logic [31:0] ea;
      logic [31:0] ed;
      total    = is1x1 ? 16 : 144;
      sent     = 0;
      cyc      = 0;
      exp_wen  = 1'b0;
      last_hs  = 1'b0;
      finished = 1'b0;
      ea       = '0;
      ed       = '0;
      n_beats  = 0;
      while (!finished && cyc < 2000) begin
         n_checks++;
         if (weight_wen !== exp_wen) begin
            n_fail++;
            $display("FAIL beat_wen: cycle %0d wen=%b required %b", cyc, weight_wen, exp_wen);
         end
         if (weight_wen === 1'b1) begin
            if (n_beats < 144) beat_addr[n_beats] = weight_waddr;
            n_beats++;
         end
         if (exp_wen) begin
            n_checks++;
            if (weight_waddr !== ea) begin
               n_fail++;
               $display("FAIL beat_waddr: beat %0d waddr=%h required %h", sent - 1, weight_waddr, ea);
            end
            n_checks++;
            if (weight_wdata !== ed) begin
               n_fail++;
               $display("FAIL beat_wdata: beat %0d wdata=%h required %h", sent - 1, weight_wdata, ed);
            end
         end
         if (last_hs) begin
            wt_valid = 1'b0;
            n_checks++;
            if (load_done !== 1'b1) begin
               n_fail++;
               $display("FAIL load_done_pulse: load_done=%b required 1", load_done);
            end
            bank_release = rel_at_done;
            step();
            bank_release = 1'b0;
            n_checks++;
            if (load_done !== 1'b0 || weight_wen !== 1'b0) begin
               n_fail++;
               $display("FAIL load_done_width: load_done=%b wen=%b required 0 0", load_done, weight_wen);
            end
            finished = 1'b1;
         end else if (abort_at >= 0 && sent == abort_at) begin
            finished = 1'b1;
         end else begin
            n_checks++;
            if (load_done !== 1'b0) begin
               n_fail++;
               $display("FAIL early_load_done: after %0d words load_done=%b required 0", sent, load_done);
            end
            wt_valid = (sent < total) && (!toggle || (cyc % 2 == 0));
            wt_data  = base + 32'(sent);
            if (wt_valid && wt_ready === 1'b1) begin
               ea      = exp_addr(is1x1, och, sent);
               ed      = wt_data;
               exp_wen = 1'b1;
               sent++;
               if (sent == total) last_hs = 1'b1;
            end else begin
               exp_wen = 1'b0;
            end
            step();
            cyc++;
         end
      end
      if (!finished) begin
         n_checks++;
         n_fail++;
         $display("FAIL stream_timeout: %0d words sent required %0d", sent, total);
      end
      wt_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      n_checks++;
      if (cmd_ready !== 1'b0 || wt_ready !== 1'b0 || weight_wen !== 1'b0 || load_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: cmd_ready=%b wt_ready=%b wen=%b load_done=%b required 0 0 0 0",
                  cmd_ready, wt_ready, weight_wen, load_done);
      end
      n_checks++;
      if (weight_waddr !== 32'd0 || weight_wdata !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_beat: waddr=%h wdata=%h required 0 0", weight_waddr, weight_wdata);
      end
      n_checks++;
      if (banks_full !== 2'd0 || err_underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_banks: banks_full=%0d err=%b required 0 0", banks_full, err_underflow);
      end
      rst_n = 1'b1;
      step();
      n_checks++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_ready: cmd_ready=%b required 1", cmd_ready);
      end
   endtask

   task automatic test_1x1();
      send_cmd(1'b1, 8'h05);
      stream(1'b1, 8'h05, 1'b0, 32'd0, -1, 1'b0);
      n_checks++;
      if (n_beats !== 16) begin
         n_fail++;
         $display("FAIL 1x1_beats: beats=%0d required 16", n_beats);
      end
      n_checks++;
      if (banks_full !== 2'd1) begin
         n_fail++;
         $display("FAIL 1x1_banks: banks_full=%0d required 1", banks_full);
      end
      pulse_release();
      n_checks++;
      if (banks_full !== 2'd0 || err_underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL 1x1_release: banks_full=%0d err=%b required 0 0", banks_full, err_underflow);
      end
   endtask

   task automatic test_3x3_toggle();
      for (int i = 0; i < 144; i++) beat_addr[i] = 32'hFFFF_FFFF;
      send_cmd(1'b0, 8'h01);
      stream(1'b0, 8'h01, 1'b1, 32'hC0DE_0000, -1, 1'b0);
      n_checks++;
      if (n_beats !== 144) begin
         n_fail++;
         $display("FAIL 3x3_beats: beats=%0d required 144", n_beats);
      end
      n_checks++;
      if (beat_addr[0] !== 32'h0080_0000) begin
         n_fail++;
         $display("FAIL 3x3_first_addr: waddr=%h required 00800000", beat_addr[0]);
      end
      n_checks++;
      if (beat_addr[16] !== 32'h0080_0040) begin
         n_fail++;
         $display("FAIL 3x3_beat16_addr: waddr=%h required 00800040", beat_addr[16]);
      end
      n_checks++;
      if (beat_addr[143] !== 32'h0080_020F) begin
         n_fail++;
         $display("FAIL 3x3_last_addr: waddr=%h required 0080020f", beat_addr[143]);
      end
      n_checks++;
      if (banks_full !== 2'd1) begin
         n_fail++;
         $display("FAIL 3x3_banks: banks_full=%0d required 1", banks_full);
      end
      pulse_release();
   endtask

   task automatic test_back_to_back();
      send_cmd(1'b1, 8'h10);
      stream(1'b1, 8'h10, 1'b0, 32'h1000, -1, 1'b0);
      n_checks++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_ready_after_done: cmd_ready=%b required 1", cmd_ready);
      end
      send_cmd(1'b1, 8'h11);
      stream(1'b1, 8'h11, 1'b0, 32'h1100, -1, 1'b0);
      n_checks++;
      if (banks_full !== 2'd2) begin
         n_fail++;
         $display("FAIL b2b_two_full: banks_full=%0d required 2", banks_full);
      end
      send_cmd(1'b1, 8'h12);
      wt_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (wt_ready !== 1'b0 || weight_wen !== 1'b0 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_wait_bank: wt_ready=%b wen=%b cmd_ready=%b required 0 0 0",
                     wt_ready, weight_wen, cmd_ready);
         end
         step();
      end
      wt_valid = 1'b0;
      pulse_release();
      n_checks++;
      if (banks_full !== 2'd1) begin
         n_fail++;
         $display("FAIL b2b_release: banks_full=%0d required 1", banks_full);
      end
      stream(1'b1, 8'h12, 1'b0, 32'h1200, -1, 1'b0);
      n_checks++;
      if (banks_full !== 2'd2) begin
         n_fail++;
         $display("FAIL b2b_third_done: banks_full=%0d required 2", banks_full);
      end
      pulse_release();
      pulse_release();
      n_checks++;
      if (banks_full !== 2'd0 || err_underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_drain: banks_full=%0d err=%b required 0 0", banks_full, err_underflow);
      end
   endtask

   task automatic test_simultaneous();
      send_cmd(1'b1, 8'h20);
      stream(1'b1, 8'h20, 1'b0, 32'h2000, -1, 1'b0);
      send_cmd(1'b1, 8'h21);
      stream(1'b1, 8'h21, 1'b0, 32'h2100, -1, 1'b1);
      n_checks++;
      if (banks_full !== 2'd1 || err_underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_inc_dec: banks_full=%0d err=%b required 1 0", banks_full, err_underflow);
      end
      pulse_release();
      n_checks++;
      if (banks_full !== 2'd0) begin
         n_fail++;
         $display("FAIL simul_drain: banks_full=%0d required 0", banks_full);
      end
   endtask

   task automatic test_underflow();
      pulse_release();
      n_checks++;
      if (banks_full !== 2'd0 || err_underflow !== 1'b1) begin
         n_fail++;
         $display("FAIL underflow: banks_full=%0d err=%b required 0 1", banks_full, err_underflow);
      end
      step();
      step();
      step();
      n_checks++;
      if (err_underflow !== 1'b1) begin
         n_fail++;
         $display("FAIL underflow_sticky: err=%b required 1", err_underflow);
      end
      send_cmd(1'b1, 8'h30);
      stream(1'b1, 8'h30, 1'b0, 32'h3000, -1, 1'b0);
      n_checks++;
      if (banks_full !== 2'd1 || err_underflow !== 1'b1) begin
         n_fail++;
         $display("FAIL underflow_after_load: banks_full=%0d err=%b required 1 1", banks_full, err_underflow);
      end
   endtask

   task automatic test_reset_midload();
      send_cmd(1'b0, 8'h02);
      stream(1'b0, 8'h02, 1'b0, 32'h4000, 50, 1'b0);
      rst_n    = 1'b0;
      wt_valid = 1'b0;
      step();
      n_checks++;
      if (cmd_ready !== 1'b0 || wt_ready !== 1'b0 || weight_wen !== 1'b0 || load_done !== 1'b0) begin
         n_fail++;
         $display("FAIL midload_reset_ctrl: cmd_ready=%b wt_ready=%b wen=%b load_done=%b required 0 0 0 0",
                  cmd_ready, wt_ready, weight_wen, load_done);
      end
      n_checks++;
      if (weight_waddr !== 32'd0 || weight_wdata !== 32'd0) begin
         n_fail++;
         $display("FAIL midload_reset_beat: waddr=%h wdata=%h required 0 0", weight_waddr, weight_wdata);
      end
      n_checks++;
      if (banks_full !== 2'd0 || err_underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL midload_reset_banks: banks_full=%0d err=%b required 0 0", banks_full, err_underflow);
      end
      rst_n = 1'b1;
      step();
      n_checks++;
      if (load_done !== 1'b0 || banks_full !== 2'd0) begin
         n_fail++;
         $display("FAIL midload_no_done: load_done=%b banks_full=%0d required 0 0", load_done, banks_full);
      end
      send_cmd(1'b1, 8'h03);
      stream(1'b1, 8'h03, 1'b0, 32'h5000, -1, 1'b0);
      n_checks++;
      if (banks_full !== 2'd1) begin
         n_fail++;
         $display("FAIL post_reset_load: banks_full=%0d required 1", banks_full);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      cmd_valid    = 1'b0;
      cmd_is_1x1   = 1'b0;
      cmd_out_ch   = 8'd0;
      wt_valid     = 1'b0;
      wt_data      = 32'd0;
      bank_release = 1'b0;
      n_beats      = 0;
      test_reset();
      test_1x1();
      test_3x3_toggle();
      test_back_to_back();
      test_simultaneous();
      test_underflow();
      test_reset_midload();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
